// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplication operand bank.
// Contents:
//   bank_state_t : operand_bank FSM state encoding
//   DEFAULT_DW   : default operand element width
//   dims_ok      : legality check for a job's matrix dimensions
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_STREAM = 3'd4,
        ST_DONE   = 3'd5
    } bank_state_t;

    localparam int DEFAULT_DW = 4;

    // A job is legal when every dimension lies in 1..n and the inner
    // dimensions agree (W columns == X rows).
    function automatic logic dims_ok(input int row_w, input int col_w,
                                     input int row_x, input int col_x,
                                     input int n);
        logic ok;
        ok = (row_w >= 32'sd1) && (row_w <= n) &&
             (col_w >= 32'sd1) && (col_w <= n) &&
             (row_x >= 32'sd1) && (row_x <= n) &&
             (col_x >= 32'sd1) && (col_x <= n) &&
             (col_w == row_x);
        return ok;
    endfunction

endpackage

// File: rtl/operand_store.sv
// N x N operand register array with one write port and two masked read ports.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   clr               : synchronous clear of the whole array
//   we, wr_row, wr_col, wr_data : single element write
//   act_rows, act_cols: active dimensions; lanes beyond them read as zero
//   col_sel / col_out : lane i = mem[i][col_sel] for i < act_rows
//   row_sel / row_out : lane j = mem[row_sel][j] for j < act_cols
module operand_store
    import mm_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int N  = 3,
    localparam int DIMW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we,
    input  logic [DIMW-1:0] wr_row,
    input  logic [DIMW-1:0] wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic [DIMW-1:0] act_rows,
    input  logic [DIMW-1:0] act_cols,
    input  logic [DIMW-1:0] col_sel,
    input  logic [DIMW-1:0] row_sel,
    output logic [N*DW-1:0] col_out,
    output logic [N*DW-1:0] row_out
);

    logic [DW-1:0] mem_r [N][N];

    // Element storage: reset, clear on a new job, or single-element write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    mem_r[i][j] <= {DW{1'b0}};
                end
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    mem_r[i][j] <= {DW{1'b0}};
                end
            end
        end else if (we) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if ((wr_row == DIMW'(i)) && (wr_col == DIMW'(j))) begin
                        mem_r[i][j] <= wr_data;
                    end
                end
            end
        end
    end

    // Masked column and row reads; exactly one j (or i) matches the select,
    // so OR-accumulating the candidates forms the mux.
    always_comb begin
        col_out = {(N*DW){1'b0}};
        row_out = {(N*DW){1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                col_out[i*DW +: DW] = col_out[i*DW +: DW] |
                    (((DIMW'(j) == col_sel) && (DIMW'(i) < act_rows)) ?
                     mem_r[i][j] : {DW{1'b0}});
                row_out[j*DW +: DW] = row_out[j*DW +: DW] |
                    (((DIMW'(i) == row_sel) && (DIMW'(j) < act_cols)) ?
                     mem_r[i][j] : {DW{1'b0}});
            end
        end
    end

endmodule

// File: rtl/operand_bank.sv
// Operand memory for the N x N MAC array. Loads W then X row-major from one
// valid/ready stream, strobes a MAC clear, then presents one W column and one
// X row per k-step with an active-cell mask, and pulses done at the end.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   start, row_w..col_x         : job request and dimensions (IDLE only)
//   in_valid, in_data, in_ready : element input stream
//   out_valid, out_ready        : k-step handshake to the MAC array
//   out_w, out_x, out_last      : k-step operands, final-step flag
//   mac_en, mac_clear           : active-cell mask, accumulator clear
//   busy, done, err             : status, completion pulse, rejected start
module operand_bank
    import mm_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int N  = 3,
    localparam int DIMW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DIMW-1:0] row_w,
    input  logic [DIMW-1:0] col_w,
    input  logic [DIMW-1:0] row_x,
    input  logic [DIMW-1:0] col_x,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_w,
    output logic [N*DW-1:0] out_x,
    output logic            out_last,
    output logic [N*N-1:0]  mac_en,
    output logic            mac_clear,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [DIMW-1:0] ONE_D = DIMW'(1);

    bank_state_t     state_r, state_s;
    logic [DIMW-1:0] rw_r, cw_r, rx_r, cx_r;
    logic [DIMW-1:0] r_cnt_r, c_cnt_r, k_r;
    logic            err_r;

    logic            start_ok_s, clr_s, accept_s, load_s;
    logic            last_elem_s, k_last_s;
    logic [DIMW-1:0] ld_rows_s, ld_cols_s;
    logic [N*DW-1:0] w_col_s, x_row_s, w_row_unused_s, x_col_unused_s;
    logic [N*N-1:0]  mask_s;

    // Shared decode used by the datapath, FSM and stores.
    always_comb begin
        start_ok_s  = dims_ok(int'(row_w), int'(col_w), int'(row_x), int'(col_x), N);
        clr_s       = (state_r == ST_IDLE) && start && start_ok_s;
        load_s      = (state_r == ST_LOAD_W) || (state_r == ST_LOAD_X);
        accept_s    = load_s && in_valid;
        ld_rows_s   = (state_r == ST_LOAD_X) ? rx_r : rw_r;
        ld_cols_s   = (state_r == ST_LOAD_X) ? cx_r : cw_r;
        last_elem_s = (r_cnt_r == (ld_rows_s - ONE_D)) && (c_cnt_r == (ld_cols_s - ONE_D));
        k_last_s    = (k_r == (cw_r - ONE_D));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = clr_s ? ST_LOAD_W : ST_IDLE;
            ST_LOAD_W: state_s = (accept_s && last_elem_s) ? ST_LOAD_X : ST_LOAD_W;
            ST_LOAD_X: state_s = (accept_s && last_elem_s) ? ST_CLEAR : ST_LOAD_X;
            ST_CLEAR:  state_s = ST_STREAM;
            ST_STREAM: state_s = (out_ready && k_last_s) ? ST_DONE : ST_STREAM;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Dimension latch, load row/col counters, k-step counter and err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_r    <= {DIMW{1'b0}};
            cw_r    <= {DIMW{1'b0}};
            rx_r    <= {DIMW{1'b0}};
            cx_r    <= {DIMW{1'b0}};
            r_cnt_r <= {DIMW{1'b0}};
            c_cnt_r <= {DIMW{1'b0}};
            k_r     <= {DIMW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok_s) begin
                            rw_r    <= row_w;
                            cw_r    <= col_w;
                            rx_r    <= row_x;
                            cx_r    <= col_x;
                            r_cnt_r <= {DIMW{1'b0}};
                            c_cnt_r <= {DIMW{1'b0}};
                            k_r     <= {DIMW{1'b0}};
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD_W, ST_LOAD_X: begin
                    // Counters restart on the final element so LOAD_X begins at (0,0).
                    if (accept_s) begin
                        if (c_cnt_r == (ld_cols_s - ONE_D)) begin
                            c_cnt_r <= {DIMW{1'b0}};
                            if (r_cnt_r == (ld_rows_s - ONE_D)) begin
                                r_cnt_r <= {DIMW{1'b0}};
                            end else begin
                                r_cnt_r <= r_cnt_r + ONE_D;
                            end
                        end else begin
                            c_cnt_r <= c_cnt_r + ONE_D;
                        end
                    end
                end
                ST_CLEAR: k_r <= {DIMW{1'b0}};
                ST_STREAM: begin
                    if (out_ready && !k_last_s) begin
                        k_r <= k_r + ONE_D;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    operand_store #(.DW(DW), .N(N)) u_w_store (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .we       (accept_s && (state_r == ST_LOAD_W)),
        .wr_row   (r_cnt_r),
        .wr_col   (c_cnt_r),
        .wr_data  (in_data),
        .act_rows (rw_r),
        .act_cols (cw_r),
        .col_sel  (k_r),
        .row_sel  (k_r),
        .col_out  (w_col_s),
        .row_out  (w_row_unused_s)
    );

    operand_store #(.DW(DW), .N(N)) u_x_store (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .we       (accept_s && (state_r == ST_LOAD_X)),
        .wr_row   (r_cnt_r),
        .wr_col   (c_cnt_r),
        .wr_data  (in_data),
        .act_rows (rx_r),
        .act_cols (cx_r),
        .col_sel  (k_r),
        .row_sel  (k_r),
        .col_out  (x_col_unused_s),
        .row_out  (x_row_s)
    );

    // Active-cell mask: bit i*N+j set for i < row_w and j < col_x.
    always_comb begin
        mask_s = {(N*N){1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mask_s[i*N + j] = (DIMW'(i) < rw_r) && (DIMW'(j) < cx_r);
            end
        end
    end

    // Output decode from registered state, counters and stores only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_w     = {(N*DW){1'b0}};
        out_x     = {(N*DW){1'b0}};
        mac_en    = {(N*N){1'b0}};
        mac_clear = 1'b0;
        busy      = (state_r != ST_IDLE);
        done      = 1'b0;
        err       = err_r;
        case (state_r)
            ST_LOAD_W, ST_LOAD_X: in_ready = 1'b1;
            ST_CLEAR:             mac_clear = 1'b1;
            ST_STREAM: begin
                out_valid = 1'b1;
                out_last  = k_last_s;
                out_w     = w_col_s;
                out_x     = x_row_s;
                mac_en    = mask_s;
            end
            ST_DONE:              done = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_operand_bank.sv
// Directed testbench for operand_bank (DW=4, N=3).
module tb_operand_bank;

    localparam int DW   = 4;
    localparam int N    = 3;
    localparam int DIMW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [DIMW-1:0] row_w, col_w, row_x, col_x;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_w, out_x;
    logic            out_last;
    logic [N*N-1:0]  mac_en;
    logic            mac_clear, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DW-1:0] wm [3][3];
    logic [DW-1:0] xm [3][3];

    operand_bank #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_w     (row_w),
        .col_w     (col_w),
        .row_x     (row_x),
        .col_x     (col_x),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_x     (out_x),
        .out_last  (out_last),
        .mac_en    (mac_en),
        .mac_clear (mac_clear),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [N*DW-1:0] exp_w(input int k, input int rw);
        logic [N*DW-1:0] v;
        v = {(N*DW){1'b0}};
        for (int i = 0; i < N; i++) begin
            if (i < rw) v[i*DW +: DW] = wm[i][k];
        end
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_x(input int k, input int cx);
        logic [N*DW-1:0] v;
        v = {(N*DW){1'b0}};
        for (int j = 0; j < N; j++) begin
            if (j < cx) v[j*DW +: DW] = xm[k][j];
        end
        return v;
    endfunction

    task automatic do_start(input int rw, input int cw, input int rx, input int cx);
        row_w = DIMW'(rw);
        col_w = DIMW'(cw);
        row_x = DIMW'(rx);
        col_x = DIMW'(cx);
        start = 1'b1;
        cyc   = 1;
        tick();
        start = 1'b0;
    endtask

    // Full job: start, load (optionally with idle gaps), clear, stream
    // (optionally stalling 2 cycles at k == stall_k), done.
    task automatic run_job(input string name, input int rw, input int cw,
                           input int rx, input int cx, input bit gap,
                           input int stall_k, input logic [N*N-1:0] exp_mac,
                           input int exp_cyc, input logic [N*DW-1:0] w0,
                           input logic [N*DW-1:0] x0);
        int idx;
        do_start(rw, cw, rx, cx);
        check({name, "/busy"}, busy, 1'b1);
        check({name, "/in_ready"}, in_ready, 1'b1);
        idx = 0;
        for (int r = 0; r < rw; r++) begin
            for (int c = 0; c < cw; c++) begin
                if (gap && idx > 0) begin
                    in_valid = 1'b0; in_data = 4'hF; tick();
                end
                in_valid = 1'b1; in_data = wm[r][c]; tick();
                idx++;
            end
        end
        for (int r = 0; r < rx; r++) begin
            for (int c = 0; c < cx; c++) begin
                if (gap) begin
                    in_valid = 1'b0; in_data = 4'hF; tick();
                end
                in_valid = 1'b1; in_data = xm[r][c]; tick();
            end
        end
        in_valid = 1'b0;
        in_data  = 4'h0;
        check({name, "/mac_clear"}, mac_clear, 1'b1);
        check({name, "/clr_in_ready"}, in_ready, 1'b0);
        check({name, "/clr_out_valid"}, out_valid, 1'b0);
        tick();
        for (int k = 0; k < cw; k++) begin
            check({name, "/out_valid"}, out_valid, 1'b1);
            check({name, "/out_w"}, out_w, exp_w(k, rw));
            check({name, "/out_x"}, out_x, exp_x(k, cx));
            check({name, "/mac_en"}, mac_en, exp_mac);
            check({name, "/out_last"}, out_last, (k == cw - 1) ? 1'b1 : 1'b0);
            if (k == 0) begin
                check({name, "/out_w_k0"}, out_w, w0);
                check({name, "/out_x_k0"}, out_x, x0);
            end
            if (k == stall_k) begin
                for (int s = 0; s < 2; s++) begin
                    tick();
                    check({name, "/hold_valid"}, out_valid, 1'b1);
                    check({name, "/hold_w"}, out_w, exp_w(k, rw));
                    check({name, "/hold_x"}, out_x, exp_x(k, cx));
                    check({name, "/hold_last"}, out_last, 1'b0);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check({name, "/done"}, done, 1'b1);
        check({name, "/done_out_valid"}, out_valid, 1'b0);
        if (exp_cyc > 0) check({name, "/cycles"}, 64'(cyc), 64'(exp_cyc));
        tick();
        check({name, "/done_pulse"}, done, 1'b0);
        check({name, "/idle_busy"}, busy, 1'b0);
    endtask

    task automatic set_t1_mats();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wm[i][j] = DW'(i * 3 + j + 1);
                xm[i][j] = (i == j) ? 4'h1 : 4'h0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        row_w = 2'd0; col_w = 2'd0; row_x = 2'd0; col_x = 2'd0;
        tick(); tick();
        check("rst/busy", busy, 1'b0);
        check("rst/in_ready", in_ready, 1'b0);
        check("rst/out_valid", out_valid, 1'b0);
        check("rst/out_w", out_w, 12'h000);
        check("rst/out_x", out_x, 12'h000);
        check("rst/mac_en", mac_en, 9'h000);
        check("rst/flags", {out_last, mac_clear, done, err}, 4'b0000);
        rst = 1'b0;
        tick();

        // 3x3 W=1..9, X=identity, no stalls
        set_t1_mats();
        run_job("t1", 3, 3, 3, 3, 1'b0, -1, 9'h1FF, 24, 12'h741, 12'h001);

        // 2x3 W times 3x1 X
        wm[0][0] = 4'd1; wm[0][1] = 4'd2; wm[0][2] = 4'd3;
        wm[1][0] = 4'd4; wm[1][1] = 4'd5; wm[1][2] = 4'd6;
        xm[0][0] = 4'd7; xm[1][0] = 4'd8; xm[2][0] = 4'd9;
        run_job("t2", 2, 3, 3, 1, 1'b0, -1, 9'b000_001_001, -1, 12'h041, 12'h007);

        // Illegal dims: col_w != row_x
        do_start(3, 2, 3, 3);
        check("t3/err", err, 1'b1);
        check("t3/busy", busy, 1'b0);
        check("t3/in_ready", in_ready, 1'b0);
        tick();
        check("t3/err_pulse", err, 1'b0);
        check("t3/busy2", busy, 1'b0);

        // Gapped input and 2-cycle stall at k=1; same results as t1
        set_t1_mats();
        run_job("t4", 3, 3, 3, 3, 1'b1, 1, 9'h1FF, -1, 12'h741, 12'h001);

        // Reset during LOAD_X after 4 X elements
        do_start(3, 3, 3, 3);
        for (int e = 0; e < 13; e++) begin
            in_valid = 1'b1;
            in_data  = (e < 9) ? wm[e / 3][e % 3] : xm[(e - 9) / 3][(e - 9) % 3];
            tick();
        end
        in_valid = 1'b0;
        check("t5/pre_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        #1;
        check("t5/busy", busy, 1'b0);
        check("t5/in_ready", in_ready, 1'b0);
        check("t5/flags", {out_valid, out_last, mac_clear, done, err}, 5'b00000);
        check("t5/outs", {out_w, out_x, mac_en}, 33'h0);
        rst = 1'b0;
        tick();
        wm[0][0] = 4'd5;
        xm[0][0] = 4'd3;
        run_job("t5b", 1, 1, 1, 1, 1'b0, -1, 9'h001, -1, 12'h005, 12'h003);

        // Back-to-back 3x3 then 2x2: unused lanes must read zero
        set_t1_mats();
        run_job("t6a", 3, 3, 3, 3, 1'b0, -1, 9'h1FF, -1, 12'h741, 12'h001);
        wm[0][0] = 4'd11; wm[0][1] = 4'd12; wm[1][0] = 4'd13; wm[1][1] = 4'd14;
        xm[0][0] = 4'd2;  xm[0][1] = 4'd3;  xm[1][0] = 4'd4;  xm[1][1] = 4'd5;
        run_job("t6b", 2, 2, 2, 2, 1'b0, -1, 9'h01B, -1, 12'h0DB, 12'h032);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_bank.md
# operand_bank

Parametrised operand memory for the matrix-multiplication accelerator. Serially loads a W matrix (row_w × col_w) and an X matrix (row_x × col_x), up to N×N, from a single input stream with valid/ready handshake. Then streams one W column and one X row per step to the N×N MAC array with an active-cell mask, a clear strobe and a completion pulse. It replaces the fixed 3×3 free-running bank with an explicit FSM, backpressure, dimension checking and reset.

## Interface
Parameters:
- DW, 4, operand element width in bits
- N, 3, maximum matrix dimension (N ≥ 2); DIMW = $clog2(N+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- row_w, col_w, row_x, col_x  in  DIMW each  job dimensions, sampled with start
- in_valid  in  1  in_data carries an element
- in_data  in  DW  element, row-major: all of W, then all of X
- in_ready  out  1  bank accepts an element this cycle
- out_valid  out  1  a k-step is presented
- out_ready  in  1  MAC array consumes the k-step
- out_w  out  N*DW  lane i = W[i][k] for i<row_w, else 0
- out_x  out  N*DW  lane j = X[k][j] for j<col_x, else 0
- out_last  out  1  qualifies the final k-step (k = col_w−1)
- mac_en  out  N*N  bit i*N+j = 1 iff i<row_w and j<col_x; valid while out_valid
- mac_clear  out  1  one-cycle strobe clearing MAC accumulators
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job completion
- err  out  1  one-cycle pulse on a rejected start

## Operation
- States: IDLE, LOAD_W, LOAD_X, CLEAR, STREAM, DONE.
- IDLE, start=1, dims legal (all nonzero, all ≤ N, col_w == row_x): latch dims, zero both stores, reset element counter and k, go LOAD_W.
- IDLE, start=1, dims illegal: err=1 next cycle; stay IDLE; stores untouched.
- LOAD_W:
  - in_ready=1; each accepted element (in_valid & in_ready) writes W[r][c] and advances c, then r.
  - On acceptance of element row_w*col_w−1, go LOAD_X.
- LOAD_X: same for X with row_x*col_x elements; on the last one, go CLEAR.
- CLEAR: mac_clear=1 for exactly one cycle, in_ready=0; go STREAM with k=0.
- STREAM:
  - out_valid=1; out_w/out_x/mac_en as defined.
  - On out_valid & out_ready: if k == col_w−1, go DONE; else k++.
  - While out_ready=0, all out_* hold stable.
- DONE: done=1 for one cycle; go IDLE. Stores keep contents until the next legal start.
- start outside IDLE is ignored; in_valid outside LOAD_* is ignored (in_ready=0).
- Counters are DIMW-bit (row/col/k) and never wrap: transitions occur on the terminal value.

## Timing
- Reset values: state IDLE; stores, counters and k zeroed; in_ready, out_valid, out_last, mac_clear, busy, done, err = 0; out_w, out_x, mac_en = 0.
- Reset asserted mid-job: immediate return to IDLE with the reset values above; no done or err.
- in_ready and out_* are decoded from registered state and stores only; no combinational path from in_valid or out_ready to any output.
- start at edge t: busy=1 and in_ready=1 from t+1.
- Zero-stall job: 1 start cycle + row_w*col_w + row_x*col_x load cycles + 1 CLEAR + col_w STREAM + 1 DONE. A 3×3 × 3×3 job takes 24 cycles from start to done inclusive.
- out_last is asserted only together with out_valid.

## Structure
- Shared package mm_pkg:
  - state enum bank_state_t
  - default DW
  - dimension-legality function dims_ok(row_w, col_w, row_x, col_x, N)
- Sub-module operand_store, instantiated twice (W, X):
  - N×N×DW register array, async-reset
  - synchronous clear and single write port (row, col, data)
  - combinational column-read port (W use) and row-read port (X use), masked to zero beyond the active dims

## Test plan
- 3×3 W = 1..9, X = identity, no stalls: three k-steps; k=0 gives out_w={7,4,1}, out_x={0,0,1} (lane 2 down to lane 0); mac_en=9'h1FF; done 24 cycles after start.
- 2×3 W, 3×1 X: mac_en=9'b000_001_001; out_x lanes 1–2 = 0; out_w lane 2 = 0; three k-steps, out_last on third.
- Start with col_w=2, row_x=3: err pulse next cycle; busy stays 0; no in_ready.
- in_valid toggling every other cycle during load, plus out_ready low for 2 cycles at k=1: only accepted elements are stored; k=1 outputs held stable; results match the no-stall run.
- rst asserted during LOAD_X after 4 X elements: all outputs return to reset values at once; a following 1×1 job (W=5, X=3) yields out_w lane0=5, out_x lane0=3, out_last=1.
- Back-to-back jobs, 3×3 then 2×2: second job's unused lanes read 0 (stores cleared on start), not stale 3×3 data.
